// File: rtl/chord_dispatcher_pkg.sv
// Shared definitions for the chord dispatcher: FSM state encoding and
// bit positions of the fields in a 16-bit song word.
package chord_dispatcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_END    = 3'd4
   } state_t;

   localparam int unsigned END_BIT = 15;
   localparam int unsigned ADV_BIT = 14;
   localparam int unsigned SLOT_HI = 13;
   localparam int unsigned SLOT_LO = 12;
   localparam int unsigned NOTE_HI = 11;
   localparam int unsigned NOTE_LO = 6;
   localparam int unsigned DUR_HI  = 5;
   localparam int unsigned DUR_LO  = 0;

endpackage

// File: rtl/chord_dispatcher_dffre.sv
// Generic register with synchronous active-high reset (to zero) and
// clock enable; reset wins over enable.
module dffre #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/chord_dispatcher.sv
// Song sequencer: fetches words from song memory, strobes per-slot loads
// and paces chord advance on the done flag of the waiter slot.
module chord_dispatcher
   import chord_dispatcher_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAITER_SLOT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_enable,
   input  logic              waiter_done,
   input  logic [15:0]       song_data,
   output logic [ADDR_W-1:0] song_addr,
   output logic [2:0]        load_slot,
   output logic [5:0]        new_note,
   output logic [5:0]        new_duration,
   output logic              song_done
);

   state_t            state;
   state_t            state_d;
   logic [2:0]        state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;
   logic              guard_q;
   logic              guard_d;

   logic              eos;
   logic              adv;
   logic [1:0]        slot;

   // play_enable gates every register, so freezing holds state, pointer
   // and the WAIT guard together.
   dffre #(.W(3)) u_state (
      .clk   (clk),
      .reset (reset),
      .en    (play_enable),
      .d     (state_d),
      .q     (state_q)
   );

   dffre #(.W(ADDR_W)) u_ptr (
      .clk   (clk),
      .reset (reset),
      .en    (play_enable),
      .d     (ptr_d),
      .q     (ptr_q)
   );

   dffre #(.W(1)) u_guard (
      .clk   (clk),
      .reset (reset),
      .en    (play_enable),
      .d     (guard_d),
      .q     (guard_q)
   );

   assign state = state_t'(state_q);

   assign eos  = song_data[END_BIT];
   assign adv  = song_data[ADV_BIT];
   assign slot = song_data[SLOT_HI:SLOT_LO];

   always_comb begin
      state_d   = state;
      ptr_d     = ptr_q;
      guard_d   = 1'b0;
      load_slot = '0;
      case (state)
         ST_IDLE:   state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            if (eos) begin
               state_d = ST_END;
            end else if (adv) begin
               load_slot[WAITER_SLOT] = 1'b1;
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = ST_WAIT;
            end else begin
               for (int unsigned i = 0; i < 3; i++) begin
                  if ((32'(slot) == i) && (i < 32'(WAITER_SLOT)))
                     load_slot[i] = 1'b1;
               end
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = ST_FETCH;
            end
         end
         ST_WAIT: begin
            // guard_q is 0 in the first WAIT cycle, so a done flag left
            // over from the previous chord cannot end the wait early.
            if (guard_q && waiter_done)
               state_d = ST_FETCH;
            else
               guard_d = 1'b1;
         end
         ST_END:    state_d = ST_END;
         default:   state_d = ST_IDLE;
      endcase
      if (!play_enable || reset)
         load_slot = '0;
   end

   assign song_addr    = ptr_q;
   assign new_note     = song_data[NOTE_HI:NOTE_LO];
   assign new_duration = song_data[DUR_HI:DUR_LO];
   assign song_done    = (state == ST_END);

endmodule

// File: tb/tb_chord_dispatcher.sv
// Directed bench for chord_dispatcher with a registered song memory model.
module tb_chord_dispatcher;

   logic        clk = 1'b0;
   logic        reset;
   logic        play_enable;
   logic        waiter_done;
   logic [15:0] song_data;
   logic [7:0]  song_addr;
   logic [2:0]  load_slot;
   logic [5:0]  new_note;
   logic [5:0]  new_duration;
   logic        song_done;

   logic [15:0] mem [256];

   int checks = 0;
   int errors = 0;

   chord_dispatcher #(.ADDR_W(8), .WAITER_SLOT(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .play_enable  (play_enable),
      .waiter_done  (waiter_done),
      .song_data    (song_data),
      .song_addr    (song_addr),
      .load_slot    (load_slot),
      .new_note     (new_note),
      .new_duration (new_duration),
      .song_done    (song_done)
   );

   always #5 clk = ~clk;

   // one-cycle read latency memory
   always @(posedge clk) song_data <= mem[song_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [15:0] w);
      for (int i = 0; i < 256; i++) mem[i] = w;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      play_enable = 1'b0;
      waiter_done = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_load(input string name, input logic [2:0] exp);
      checks++;
      if (load_slot !== exp) begin
         errors++;
         $display("FAIL %s load_slot got %b expected %b", name, load_slot, exp);
      end
   endtask

   task automatic chk_addr(input string name, input logic [7:0] exp);
      checks++;
      if (song_addr !== exp) begin
         errors++;
         $display("FAIL %s song_addr got %0d expected %0d", name, song_addr, exp);
      end
   endtask

   task automatic chk_done(input string name, input logic exp);
      checks++;
      if (song_done !== exp) begin
         errors++;
         $display("FAIL %s song_done got %b expected %b", name, song_done, exp);
      end
   endtask

   task automatic test_reset();
      fill(16'h8000);
      do_reset();
      chk_addr("reset_addr", 8'd0);
      chk_load("reset_load", 3'b000);
      chk_done("reset_done", 1'b0);
   endtask

   task automatic test_load();
      fill(16'h8000);
      mem[0] = 16'h0C84;
      mem[1] = 16'h1103;
      do_reset();
      play_enable = 1'b1;
      #1;
      chk_load("load_idle", 3'b000);
      tick();
      chk_load("load_fetch0", 3'b000);
      tick();
      chk_load("load_decode0", 3'b001);
      // 0x0C84: bits[11:6] = 6'b110010 = 50, bits[5:0] = 4
      checks++;
      if (new_note !== 6'd50 || new_duration !== 6'd4) begin
         errors++;
         $display("FAIL load_fields note/dur got %0d/%0d expected 50/4", new_note, new_duration);
      end
      tick();
      chk_load("load_fetch1", 3'b000);
      chk_addr("load_addr1", 8'd1);
      tick();
      chk_load("load_decode1", 3'b010);
      checks++;
      if (new_note !== 6'd4 || new_duration !== 6'd3) begin
         errors++;
         $display("FAIL load_fields1 note/dur got %0d/%0d expected 4/3", new_note, new_duration);
      end
      tick();
      tick();
      chk_load("load_end_decode", 3'b000);
      tick();
      chk_done("load_end_done", 1'b1);
      chk_addr("load_end_addr", 8'd2);
   endtask

   task automatic test_advance();
      fill(16'h8000);
      mem[0] = 16'h4285;
      mem[1] = 16'h0C84;
      do_reset();
      waiter_done = 1'b1;
      play_enable = 1'b1;
      tick();
      tick();
      chk_load("adv_decode", 3'b100);
      tick();
      chk_load("adv_wait1", 3'b000);
      chk_addr("adv_wait_addr", 8'd1);
      tick();
      chk_load("adv_wait2", 3'b000);
      tick();
      chk_load("adv_fetch", 3'b000);
      tick();
      chk_load("adv_next_decode", 3'b001);
   endtask

   task automatic test_wait_hold();
      fill(16'h8000);
      mem[0] = 16'h4285;
      mem[1] = 16'h1103;
      do_reset();
      play_enable = 1'b1;
      tick();
      tick();
      chk_load("hold_decode", 3'b100);
      begin
         int bad = 0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (load_slot !== 3'b000 || song_addr !== 8'd1) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL hold_wait left WAIT in %0d cycles, expected 0", bad);
         end
      end
      waiter_done = 1'b1;
      tick();
      chk_load("hold_fetch", 3'b000);
      tick();
      chk_load("hold_release", 3'b010);
      waiter_done = 1'b0;
   endtask

   task automatic test_nop_end();
      fill(16'h8000);
      mem[0] = 16'h3000;
      mem[1] = 16'h8000;
      do_reset();
      play_enable = 1'b1;
      tick();
      tick();
      chk_load("nop_decode", 3'b000);
      tick();
      chk_addr("nop_addr", 8'd1);
      tick();
      chk_load("end_decode", 3'b000);
      chk_done("end_decode_done", 1'b0);
      tick();
      chk_done("end_done", 1'b1);
      chk_addr("end_addr", 8'd1);
      play_enable = 1'b0;
      tick();
      play_enable = 1'b1;
      waiter_done = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk_done("end_sticky", 1'b1);
      chk_addr("end_sticky_addr", 8'd1);
      chk_load("end_sticky_load", 3'b000);
      waiter_done = 1'b0;
   endtask

   task automatic test_freeze();
      fill(16'h8000);
      mem[0] = 16'h0C84;
      do_reset();
      play_enable = 1'b1;
      tick();
      tick();
      play_enable = 1'b0;
      #1;
      chk_load("frz_drop", 3'b000);
      begin
         int bad = 0;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (load_slot !== 3'b000 || song_addr !== 8'd0) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL frz_hold activity in %0d cycles, expected 0", bad);
         end
      end
      play_enable = 1'b1;
      #1;
      chk_load("frz_resume", 3'b001);
      checks++;
      if (new_note !== 6'd50 || new_duration !== 6'd4) begin
         errors++;
         $display("FAIL frz_fields note/dur got %0d/%0d expected 50/4", new_note, new_duration);
      end
      tick();
      chk_addr("frz_addr", 8'd1);
   endtask

   task automatic test_wrap();
      int n;
      fill(16'h3000);
      do_reset();
      play_enable = 1'b1;
      n = 0;
      while (song_addr !== 8'd255 && n < 1000) begin
         tick();
         if (load_slot !== 3'b000) begin
            checks++;
            errors++;
            $display("FAIL wrap_nop load_slot got %b expected 000", load_slot);
         end
         n++;
      end
      chk_addr("wrap_reach255", 8'd255);
      tick();
      tick();
      chk_addr("wrap_zero", 8'd0);
      chk_done("wrap_done", 1'b0);
   endtask

   task automatic test_reset_mid_wait();
      fill(16'h8000);
      mem[0] = 16'h4285;
      do_reset();
      play_enable = 1'b1;
      tick();
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk_load("rst_wait_load_during", 3'b000);
      tick();
      chk_addr("rst_wait_addr", 8'd0);
      chk_done("rst_wait_done", 1'b0);
      chk_load("rst_wait_load", 3'b000);
      reset = 1'b0;
      tick();
      chk_load("rst_wait_fetch", 3'b000);
      tick();
      chk_load("rst_wait_redecode", 3'b100);
   endtask

   initial begin
      reset       = 1'b1;
      play_enable = 1'b0;
      waiter_done = 1'b0;
      test_reset();
      test_load();
      test_advance();
      test_wait_hold();
      test_nop_end();
      test_freeze();
      test_wrap();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
